// File: rtl/accel_pkg.sv
// Shared accelerator definitions: RoCC command field layout and interface widths.
package accel_pkg;

  localparam int unsigned CMD_NBITS  = 160;
  localparam int unsigned RESP_NBITS = 74;

  localparam int unsigned FUNCT_LSB    = 0;
  localparam int unsigned FUNCT_W      = 7;
  localparam int unsigned RS2_LSB      = 7;
  localparam int unsigned RS2_W        = 5;
  localparam int unsigned RS1_LSB      = 12;
  localparam int unsigned RS1_W        = 5;
  localparam int unsigned XD_BIT       = 17;
  localparam int unsigned XS1_BIT      = 18;
  localparam int unsigned XS2_BIT      = 19;
  localparam int unsigned RD_LSB       = 20;
  localparam int unsigned RD_W         = 5;
  localparam int unsigned OPCODE_LSB   = 25;
  localparam int unsigned OPCODE_W     = 7;
  localparam int unsigned RS1_DATA_LSB = 32;
  localparam int unsigned RS2_DATA_LSB = 96;
  localparam int unsigned DATA_W       = 64;

  function automatic logic [CMD_NBITS-1:0] rocc_cmd_pack(
    input logic [6:0]  funct,
    input logic [4:0]  rs2,
    input logic [4:0]  rs1,
    input logic        xd,
    input logic        xs1,
    input logic        xs2,
    input logic [4:0]  rd,
    input logic [6:0]  opcode,
    input logic [63:0] rs1_data,
    input logic [63:0] rs2_data
  );
    logic [CMD_NBITS-1:0] c;
    c = '0;
    c[FUNCT_LSB +: FUNCT_W]     = funct;
    c[RS2_LSB +: RS2_W]         = rs2;
    c[RS1_LSB +: RS1_W]         = rs1;
    c[XD_BIT]                   = xd;
    c[XS1_BIT]                  = xs1;
    c[XS2_BIT]                  = xs2;
    c[RD_LSB +: RD_W]           = rd;
    c[OPCODE_LSB +: OPCODE_W]   = opcode;
    c[RS1_DATA_LSB +: DATA_W]   = rs1_data;
    c[RS2_DATA_LSB +: DATA_W]   = rs2_data;
    return c;
  endfunction

endpackage

// File: rtl/accel_cmd_storage.sv
// Command slot array: one synchronous write port, asynchronous read port, no reset.
module accel_cmd_storage #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CMD_NBITS = 160
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [CMD_NBITS-1:0]     wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [CMD_NBITS-1:0]     rd_data_o
);

  logic [CMD_NBITS-1:0] mem_q [DEPTH];
  logic [CMD_NBITS-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) begin
      mem_d[wr_addr_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/accel_cmd_queue.sv
// Command FIFO between the core and the accelerator cmd port.
// Define ACCEL_CMD_QUEUE_BYPASS_EN to forward commands combinationally while the queue is empty.
module accel_cmd_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CMD_NBITS = accel_pkg::CMD_NBITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CMD_NBITS-1:0]       in_cmd,
  input  logic                       in_cmd_vld,
  output logic                       in_cmd_rdy,
  output logic [CMD_NBITS-1:0]       out_cmd,
  output logic                       out_cmd_vld,
  input  logic                       out_cmd_rdy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  import accel_pkg::*;

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0]      head_q, head_d;
  logic [PtrW-1:0]      tail_q, tail_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 empty, full, push, pop;
  logic [CMD_NBITS-1:0] rd_data;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));

  always_comb begin
    in_cmd_rdy = !full;
`ifdef ACCEL_CMD_QUEUE_BYPASS_EN
    out_cmd_vld = !empty || in_cmd_vld;
    out_cmd     = empty ? in_cmd : rd_data;
    // A command consumed straight through the bypass never occupies a slot.
    push        = in_cmd_vld && !full && !(empty && out_cmd_rdy);
`else
    out_cmd_vld = !empty;
    out_cmd     = rd_data;
    push        = in_cmd_vld && !full;
`endif
    pop = !empty && out_cmd_rdy;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      tail_d = tail_q + PtrW'(1);
    end
    if (pop) begin
      head_d = head_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  accel_cmd_storage #(
    .DEPTH     (DEPTH),
    .CMD_NBITS (CMD_NBITS)
  ) u_storage (
    .clk_i     (clk),
    .wr_en_i   (push && !rst),
    .wr_addr_i (tail_q),
    .wr_data_i (in_cmd),
    .rd_addr_i (head_q),
    .rd_data_o (rd_data)
  );

  assign count = count_q;

endmodule

// File: tb/tb_accel_cmd_queue.sv
// Scoreboard bench for accel_cmd_queue; honours ACCEL_CMD_QUEUE_BYPASS_EN when defined.
module tb_accel_cmd_queue;
  import accel_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NB    = CMD_NBITS;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef ACCEL_CMD_QUEUE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] in_cmd = '0;
  logic          in_cmd_vld = 1'b0;
  logic          in_cmd_rdy;
  logic [NB-1:0] out_cmd;
  logic          out_cmd_vld;
  logic          out_cmd_rdy = 1'b0;
  logic [CW-1:0] count;

  accel_cmd_queue #(
    .DEPTH     (DEPTH),
    .CMD_NBITS (NB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_cmd      (in_cmd),
    .in_cmd_vld  (in_cmd_vld),
    .in_cmd_rdy  (in_cmd_rdy),
    .out_cmd     (out_cmd),
    .out_cmd_vld (out_cmd_vld),
    .out_cmd_rdy (out_cmd_rdy),
    .count       (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_emit   = 0;
  logic [NB-1:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] mk(input int i);
    return rocc_cmd_pack(7'(i), 5'(i + 1), 5'(i + 2), i[0], i[1], i[2], 5'(i + 3), 7'(i * 3),
                         {32'hA5A5_0000, i}, {i, ~i});
  endfunction

  // Reference model: evaluated mid-cycle, where inputs and outputs are stable before the next edge.
  always @(negedge clk) begin : mon
    int sz;
    bit byp_now, e_rdy, e_vld, do_push, do_pop;
    if (rst) begin
      exp_q.delete();
    end else begin
      sz      = exp_q.size();
      byp_now = Bypass && (sz == 0) && in_cmd_vld;
      e_rdy   = (sz != DEPTH);
      e_vld   = (sz != 0) || byp_now;
      check_eq("in_cmd_rdy", NB'(in_cmd_rdy), NB'(e_rdy));
      check_eq("out_cmd_vld", NB'(out_cmd_vld), NB'(e_vld));
      check_eq("count", NB'(count), NB'(sz));
      if (e_vld) check_eq("out_cmd", out_cmd, (sz != 0) ? exp_q[0] : in_cmd);
      do_push = in_cmd_vld && e_rdy && !(byp_now && out_cmd_rdy);
      do_pop  = (sz != 0) && out_cmd_rdy;
      if (e_vld && out_cmd_rdy) n_emit++;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(in_cmd);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    check_eq("reset_count", NB'(count), NB'(0));

    // Single command
    in_cmd      = rocc_cmd_pack(7'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 7'd0, 64'd5, 64'd7);
    in_cmd_vld  = 1'b1;
    out_cmd_rdy = 1'b1;
    step(1);
    in_cmd_vld = 1'b0;
    step(2);
    check_eq("single_count", NB'(count), NB'(0));

    // Fill with the sink stalled; the fifth push must bounce
    out_cmd_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_cmd     = mk(i);
      in_cmd_vld = 1'b1;
      step(1);
    end
    in_cmd_vld = 1'b0;
    check_eq("fill_count", NB'(count), NB'(4));
    check_eq("fill_rdy", NB'(in_cmd_rdy), NB'(0));

    // Drain
    base        = n_emit;
    out_cmd_rdy = 1'b1;
    step(5);
    check_eq("drain_emitted", NB'(n_emit - base), NB'(4));
    check_eq("drain_vld", NB'(out_cmd_vld), NB'(0));

    // Streaming through the pointer wrap
    base = n_emit;
    for (int i = 0; i < 10; i++) begin
      in_cmd     = mk(100 + i);
      in_cmd_vld = 1'b1;
      step(1);
    end
    in_cmd_vld = 1'b0;
    step(2);
    check_eq("wrap_emitted", NB'(n_emit - base), NB'(10));

    // Reset with three queued commands and a handshake in the same cycle
    out_cmd_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_cmd     = mk(300 + i);
      in_cmd_vld = 1'b1;
      step(1);
    end
    check_eq("pre_rst_count", NB'(count), NB'(3));
    rst         = 1'b1;
    out_cmd_rdy = 1'b1;
    in_cmd      = mk(399);
    step(1);
    rst        = 1'b0;
    in_cmd_vld = 1'b0;
    check_eq("post_rst_count", NB'(count), NB'(0));
    check_eq("post_rst_vld", NB'(out_cmd_vld), NB'(0));
    check_eq("post_rst_rdy", NB'(in_cmd_rdy), NB'(1));
    base = n_emit;
    step(3);
    check_eq("post_rst_emitted", NB'(n_emit - base), NB'(0));

    // Push into an empty queue with the sink ready
    in_cmd     = mk(500);
    in_cmd_vld = 1'b1;
    #1;
    check_eq("bypass_vld", NB'(out_cmd_vld), NB'(Bypass));
    step(1);
    in_cmd_vld = 1'b0;
    check_eq("bypass_count", NB'(count), NB'(Bypass ? 0 : 1));
    step(2);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      in_cmd      = mk(int'($urandom));
      in_cmd_vld  = 1'($urandom_range(0, 1));
      out_cmd_rdy = 1'($urandom_range(0, 2) != 0);
      step(1);
    end
    in_cmd_vld  = 1'b0;
    out_cmd_rdy = 1'b1;
    step(DEPTH + 2);
    check_eq("final_count", NB'(count), NB'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/accel_cmd_queue.md
ACCEL_CMD_QUEUE -- requirements
Module: accel_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of command entries (power of two, at least 2).
REQ-002 SHALL have parameter CMD_NBITS, default 160, the command width in the packed RoCC layout (funct[6:0], rs2[11:7], rs1[16:12], xd[17], xs1[18], xs2[19], rd[24:20], opcode[31:25], rs1_data[95:32], rs2_data[159:96]).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state on posedge.
REQ-004 SHALL have port rst, input, 1 bit, the reset; synchronous, active-high.
REQ-005 SHALL have port in_cmd, input, CMD_NBITS bits, the command from the core.
REQ-006 SHALL have port in_cmd_vld, input, 1 bit, marking in_cmd valid.
REQ-007 SHALL have port in_cmd_rdy, output, 1 bit, marking that the queue accepts in_cmd.
REQ-008 SHALL have port out_cmd, output, CMD_NBITS bits, the command toward the accelerator's cmd input.
REQ-009 SHALL have port out_cmd_vld, output, 1 bit, marking out_cmd valid.
REQ-010 SHALL have port out_cmd_rdy, input, 1 bit, the accelerator's cmd_rdy.
REQ-011 SHALL have port count, output, $clog2(DEPTH+1) bits, the current occupancy.

Function
REQ-012 SHALL enqueue in_cmd when in_cmd_vld && in_cmd_rdy on a posedge, writing the slot at tail_ptr and advancing tail_ptr modulo DEPTH.
REQ-013 SHALL dequeue when out_cmd_vld && out_cmd_rdy on a posedge, advancing head_ptr modulo DEPTH.
REQ-014 SHALL drive in_cmd_rdy = (count != DEPTH), with no combinational path from out_cmd_rdy.
REQ-015 SHALL drive out_cmd_vld = (count != 0) and out_cmd = storage[head_ptr]; out_cmd is don't-care while out_cmd_vld is 0.
REQ-016 SHALL give a latency of exactly 1 cycle: a command enqueued at edge N is presented at out_cmd from edge N onward.
REQ-017 SHALL, on a simultaneous enqueue and dequeue, advance both pointers and leave count unchanged.
REQ-018 SHALL, when full, refuse input (in_cmd_rdy=0) even if out_cmd_rdy=1 in the same cycle; a dequeue in that cycle makes in_cmd_rdy=1 the next cycle.
REQ-019 SHALL wrap pointers from DEPTH-1 to 0 with no loss or reordering; the output order is strictly FIFO.
REQ-020 SHALL never alter out_cmd while out_cmd_vld=1 and out_cmd_rdy=0.

Reset
REQ-021 SHALL, while rst=1, set count=0, head_ptr=0 and tail_ptr=0, so that in_cmd_rdy=1 and out_cmd_vld=0 on the cycle after rst is sampled.
REQ-022 SHALL, on rst asserted mid-operation, discard all queued commands and ignore any handshake in the same cycle; storage contents are not reset.

Configuration
REQ-023 SHALL, when ACCEL_CMD_QUEUE_BYPASS_EN is defined, pass in_cmd combinationally to out_cmd with out_cmd_vld=in_cmd_vld whenever count==0.
REQ-024 SHALL, in bypass mode, not enqueue a command that is consumed in the same cycle (in_cmd_vld && out_cmd_rdy with count==0), and SHALL enqueue it normally otherwise.
REQ-025 SHALL, when ACCEL_CMD_QUEUE_BYPASS_EN is undefined, exhibit exactly the REQ-015/REQ-016 behaviour with no in-to-out combinational path.

Structure
REQ-026 SHALL place the RoCC command field offsets and widths, plus the CMD_NBITS and RESP_NBITS (74) constants, in the shared package accel_pkg.
REQ-027 SHALL implement storage in one sub-module, accel_cmd_storage: a DEPTH x CMD_NBITS register array with a write port and an asynchronous read port and no reset.

Verification
REQ-028 SHALL cover single command: rst, then in_cmd=rs1_data 5/rs2_data 7/rd 3 with out_cmd_rdy=1 -> out_cmd_vld=1 on the next cycle with identical bits, and count returns to 0 after the handshake.
REQ-029 SHALL cover fill: out_cmd_rdy=0 while pushing 5 commands -> count=4, in_cmd_rdy=0 after the 4th, and the 5th is not accepted.
REQ-030 SHALL cover drain order: after the fill, out_cmd_rdy=1 -> commands 1..4 appear in order on 4 consecutive cycles, then out_cmd_vld=0.
REQ-031 SHALL cover wrap and simultaneous traffic: 10 commands with in_cmd_vld and out_cmd_rdy both held high -> all 10 emerge in order, and count stays at 1 in steady state.
REQ-032 SHALL cover mid-operation reset: rst pulsed with count=3 -> count=0, out_cmd_vld=0 and in_cmd_rdy=1 the next cycle, with no stale command emitted.
REQ-033 SHALL cover bypass (with ACCEL_CMD_QUEUE_BYPASS_EN, empty queue, out_cmd_rdy=1): in_cmd_vld=1 -> out_cmd_vld=1 in the same cycle and count stays 0.
